// File: rtl/transpose_pkg.sv
// Shared types and default geometry for the transpose core and its input arbiter.
// The core's memory controller imports the same defaults so both sides agree on tile shape.
package transpose_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int NUM_PE_DEF     = 8;
    localparam int NUM_REQ_DEF    = 4;
    localparam int ID_W_DEF       = $clog2(NUM_REQ_DEF);
    localparam int CNT_W_DEF      = $clog2(NUM_PE_DEF);

    typedef logic [ID_W_DEF-1:0]  req_id_t;
    typedef logic [CNT_W_DEF-1:0] beat_cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/transpose_tag_fifo.sv
// Two-entry in-order FIFO of requester ids, one entry per core bank in flight.
// A push is accepted while full only when a pop retires the head in the same cycle.
module transpose_tag_fifo #(
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] head,
    output logic            full,
    output logic            empty
);

    logic [ID_W-1:0] mem_q [2];
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [1:0]      count_q,  count_d;
    logic            do_push, do_pop;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q ^ do_pop;
        wr_ptr_d = wr_ptr_q ^ do_push;
        count_d  = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

endmodule

// File: rtl/transpose_arbiter.sv
// Round-robin block arbiter in front of a shared transpose core; routes transposed
// output blocks back to their owner through an in-order tag queue.
module transpose_arbiter
    import transpose_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_PE     = NUM_PE_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int CNT_W      = $clog2(NUM_PE),
    parameter int BEAT_W     = DATA_WIDTH * NUM_PE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_REQ-1:0] req_val,
    output logic [NUM_REQ-1:0] req_rdy,
    input  logic [BEAT_W-1:0] req_data [NUM_REQ],
    input  logic              core_rdy,
    output logic              core_val,
    output logic [BEAT_W-1:0] core_data,
    input  logic              core_out_val,
    input  logic [BEAT_W-1:0] core_out_data,
    output logic [NUM_REQ-1:0] resp_val,
    output logic [ID_W-1:0]   resp_id,
    output logic [BEAT_W-1:0] resp_data,
    output logic              err_orphan
);

    arb_state_e       state_q,      state_d;
    logic [ID_W-1:0]  gnt_id_q,     gnt_id_d;
    logic [ID_W-1:0]  rr_ptr_q,     rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q,   beat_cnt_d;
    logic [CNT_W-1:0] out_cnt_q,    out_cnt_d;
    logic             err_orphan_q, err_orphan_d;

    logic             tag_push, tag_pop, tag_full, tag_empty;
    logic [ID_W-1:0]  tag_head;
    logic             pick_found;
    logic [ID_W-1:0]  pick_id;
    logic             beat, out_beat;

    transpose_tag_fifo #(
        .ID_W (ID_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tag_push),
        .push_id (pick_id),
        .pop     (tag_pop),
        .head    (tag_head),
        .full    (tag_full),
        .empty   (tag_empty)
    );

    // Cyclic search starting just past the last winner.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_found && req_val[ID_W'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign req_rdy[gi]  = (state_q == XFER) && (gnt_id_q == ID_W'(gi)) && core_rdy;
            assign resp_val[gi] = out_beat && (tag_head == ID_W'(gi));
        end
    endgenerate

    assign beat       = (state_q == XFER) && req_val[gnt_id_q] && core_rdy;
    assign core_val   = beat;
    assign core_data  = req_data[gnt_id_q];
    assign out_beat   = core_out_val && !tag_empty;
    assign resp_id    = tag_head;
    assign resp_data  = core_out_data;
    assign err_orphan = err_orphan_q;

    always_comb begin
        state_d      = state_q;
        gnt_id_d     = gnt_id_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        out_cnt_d    = out_cnt_q;
        err_orphan_d = err_orphan_q || (core_out_val && tag_empty);
        tag_push     = 1'b0;
        tag_pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found && !tag_full) begin
                    gnt_id_d = pick_id;
                    tag_push = 1'b1;
                    state_d  = XFER;
                end
            end
            XFER: begin
                if (beat) begin
                    if (beat_cnt_q == CNT_W'(NUM_PE - 1)) begin
                        beat_cnt_d = '0;
                        rr_ptr_d   = gnt_id_q;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Orphan beats are dropped and do not advance the output block count.
        if (out_beat) begin
            if (out_cnt_q == CNT_W'(NUM_PE - 1)) begin
                out_cnt_d = '0;
                tag_pop   = 1'b1;
            end else begin
                out_cnt_d = out_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_id_q     <= '0;
            rr_ptr_q     <= ID_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            out_cnt_q    <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_id_q     <= gnt_id_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            out_cnt_q    <= out_cnt_d;
            err_orphan_q <= err_orphan_d;
        end
    end

endmodule

// File: tb/tb_transpose_arbiter.sv
// Directed bench for transpose_arbiter: grant order, block locking, stalls, tag queue, orphan, reset.
module tb_transpose_arbiter;

    localparam int DW = 8;
    localparam int PE = 8;
    localparam int NR = 4;
    localparam int BW = DW * PE;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_val;
    logic [NR-1:0] req_rdy;
    logic [BW-1:0] req_data [NR];
    logic          core_rdy;
    logic          core_val;
    logic [BW-1:0] core_data;
    logic          core_out_val;
    logic [BW-1:0] core_out_data;
    logic [NR-1:0] resp_val;
    logic [1:0]    resp_id;
    logic [BW-1:0] resp_data;
    logic          err_orphan;

    int checks = 0;
    int errors = 0;
    int cnt [NR];

    transpose_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_PE     (PE),
        .NUM_REQ    (NR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_val       (req_val),
        .req_rdy       (req_rdy),
        .req_data      (req_data),
        .core_rdy      (core_rdy),
        .core_val      (core_val),
        .core_data     (core_data),
        .core_out_val  (core_out_val),
        .core_out_data (core_out_data),
        .resp_val      (resp_val),
        .resp_id       (resp_id),
        .resp_data     (resp_data),
        .err_orphan    (err_orphan)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] beat_data(input int id, input int b);
        return 64'hC0DE_0000_0000_0000 | 64'(id * 256 + b);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_bench_data();
        for (int i = 0; i < NR; i++) begin
            cnt[i]      = 0;
            req_data[i] = beat_data(i, 0);
        end
    endtask

    // Advance one clock; bench-side beat counters follow accepted handshakes.
    task automatic tick();
        logic [NR-1:0] hs;
        hs = req_val & req_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) begin
                cnt[i]++;
                req_data[i] = beat_data(i, cnt[i]);
            end
        end
        #1;
    endtask

    // Expect one block of PE contiguous beats from requester id; optional one-cycle stall.
    task automatic xfer_block(input int id, input int stall_at);
        int beats;
        int cyc;
        bit stalled;
        beats   = 0;
        cyc     = 0;
        stalled = 0;
        while (beats < PE && cyc < 40) begin
            core_rdy = 1'b1;
            if (beats == stall_at && !stalled) begin
                core_rdy = 1'b0;
                stalled  = 1;
            end
            #1;
            if (!core_rdy) begin
                check("stall_rdy", 64'(req_rdy), 64'(0));
                check("stall_val", 64'(core_val), 64'(0));
            end else if (beats > 0 || core_val) begin
                check("blk_contig", 64'(core_val), 64'(1));
                check("blk_owner", 64'(req_rdy), 64'(1 << id));
                check("blk_data", core_data, beat_data(id, cnt[id]));
                beats++;
            end
            tick();
            cyc++;
        end
        core_rdy = 1'b1;
        check("blk_beats", 64'(beats), 64'(PE));
    endtask

    // Feed PE transposed beats; check they are routed to requester id.
    task automatic drain(input int id, input bit hold_req0);
        for (int b = 0; b < PE; b++) begin
            core_out_val  = 1'b1;
            core_out_data = 64'h0DD0_0000_0000_0000 | 64'(id * 16 + b);
            #1;
            check("resp_val", 64'(resp_val), 64'(1 << id));
            check("resp_id", 64'(resp_id), 64'(id));
            check("resp_data", resp_data, 64'h0DD0_0000_0000_0000 | 64'(id * 16 + b));
            if (hold_req0) check("full_hold", 64'(req_rdy), 64'(0));
            tick();
        end
        core_out_val = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_val = '0;
        core_rdy = 1'b1;
        core_out_val = 1'b0;
        core_out_data = '0;
        reset_bench_data();
        tick();
        tick();
        check("rst_req_rdy", 64'(req_rdy), 64'(0));
        check("rst_core_val", 64'(core_val), 64'(0));
        check("rst_resp_val", 64'(resp_val), 64'(0));
        check("rst_err", 64'(err_orphan), 64'(0));
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int beats;
        do_reset();

        // Single requester 2: one bubble, then 8 beats, responses back to 2.
        req_val = 4'b0100;
        #1;
        check("t1_bubble", 64'(req_rdy), 64'(0));
        xfer_block(2, -1);
        req_val = '0;
        #1;
        drain(2, 0);
        // Queue should now be empty: a further output beat is an orphan.
        core_out_val = 1'b1;
        #1;
        check("t5_orphan_resp", 64'(resp_val), 64'(0));
        tick();
        core_out_val = 1'b0;
        #1;
        check("t5_err_set", 64'(err_orphan), 64'(1));
        tick();
        tick();
        check("t5_err_sticky", 64'(err_orphan), 64'(1));

        // All requesters active from reset: blocks in order 0,1,2,3,0.
        do_reset();
        req_val = 4'b1111;
        xfer_block(0, -1);
        xfer_block(1, -1);
        drain(0, 0);
        xfer_block(2, -1);
        drain(1, 0);
        xfer_block(3, -1);
        drain(2, 0);
        xfer_block(0, -1);
        req_val = '0;
        #1;
        drain(3, 0);
        drain(0, 0);

        // core_rdy low for one cycle at beat 5 of a block from requester 1.
        req_val = 4'b0010;
        xfer_block(1, 5);
        req_val = '0;
        #1;
        drain(1, 0);

        // Two blocks outstanding (1 then 3) fill the queue; req 0 waits for the pop.
        req_val = 4'b0010;
        xfer_block(1, -1);
        req_val = 4'b1000;
        xfer_block(3, -1);
        req_val = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t4_full_block", 64'(req_rdy), 64'(0));
            tick();
        end
        drain(1, 1);
        check("t4_arb_bubble", 64'(req_rdy), 64'(0));
        tick();
        check("t4_req0_grant", 64'(req_rdy), 64'(1));
        xfer_block(0, -1);
        req_val = '0;
        #1;
        drain(3, 0);
        drain(0, 0);

        // Reset in the middle of a block from requester 2.
        req_val = 4'b0100;
        beats = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (core_val) begin
                if (beats == 4) break;
                beats++;
            end
            tick();
        end
        check("t6_beats_before_rst", 64'(beats), 64'(4));
        core_out_val = 1'b1;
        #1;
        check("t6_resp_before_rst", 64'(resp_val), 64'(4'b0100));
        rst = 1'b1;
        #1;
        check("t6_rst_req_rdy", 64'(req_rdy), 64'(0));
        check("t6_rst_core_val", 64'(core_val), 64'(0));
        check("t6_rst_resp_val", 64'(resp_val), 64'(0));
        core_out_val = 1'b0;
        tick();
        reset_bench_data();
        rst = 1'b0;
        req_val = 4'b1111;
        #1;
        check("t6_bubble", 64'(req_rdy), 64'(0));
        tick();
        check("t6_first_req0", 64'(req_rdy), 64'(1));
        check("t6_err_clear", 64'(err_orphan), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
